core_res_packer: RTL
====================

// Module: core_res_packer
// PURPOSE
//  - Receive end of the core result path: takes the 18-bit o_res stream from core, normalizes and clips it to 8-bit pixels.
//  - Packs PACK_N pixels little-endian into one output word with a byte-keep mask and row-end flag.
//  - Buffers words in a FIFO_DEPTH-deep FIFO; drives a valid/ready output toward the output writer.
//  - Gives backpressure to the core issue logic via o_res_rdy.
// PARAMETERS
//  RES_W       18  width of core result (unsigned)
//  PIX_W       8   output pixel width
//  PACK_N      8   pixels per output word (power of 2, 2..16)
//  FIFO_DEPTH  4   output word FIFO depth (power of 2, >=2)
//  SHIFT       0   right-shift applied to result before clipping (0..RES_W-1)
// PORTS
//  clk        in   1              clock, all logic rising-edge
//  rst_n      in   1              asynchronous active-low reset
//  i_res_vld  in   1              result sample valid
//  i_res      in   RES_W          core result (unsigned)
//  i_last     in   1              sample is last of row; qualified by i_res_vld
//  o_res_rdy  out  1              packer can accept a sample this cycle
//  o_data     out  PACK_N*PIX_W   packed word; lane 0 = bits [PIX_W-1:0] = oldest pixel
//  o_keep     out  PACK_N         lane-valid mask
//  o_last     out  1              word closes a row
//  o_vld      out  1              FIFO head valid
//  i_rdy      in   1              downstream accepts word
//  o_sat_cnt  out  16             saturated-sample count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async assert, sync release): lane count=0, partial word and keep cleared, FIFO empty;
//    o_vld=0, o_data=0, o_keep=0, o_last=0, o_sat_cnt=0, o_res_rdy=1 after release.
//  - Accept: i_res_vld & o_res_rdy. o_res_rdy = (fifo_count < FIFO_DEPTH), from registered count only.
//  - Pixel: p = i_res >> SHIFT (logical); if p > 2**PIX_W-1 then p = 2**PIX_W-1 (saturated), else p[PIX_W-1:0].
//  - Packing: accepted pixel written to lane lane_cnt, keep bit set, lane_cnt++.
//  - Word close: the accepted sample fills lane PACK_N-1, or i_last=1.
//    - Close pushes {data, keep, last=i_last} into the FIFO in the same cycle.
//    - Close clears lane_cnt, partial data and keep.
//    - Unused lanes read 0 with keep bit 0.
//  - i_last on lane PACK_N-1: keep all ones, o_last=1.
//  - i_last ignored when i_res_vld=0.
//  - Latency: closing sample accepted in cycle N -> word at FIFO output, o_vld=1, in cycle N+1 (FIFO empty).
//  - Output: show-ahead FIFO; o_data/o_keep/o_last are stable while o_vld & !i_rdy. Pop when o_vld & i_rdy.
//  - Full FIFO: o_res_rdy=0 and no samples accepted. A pop frees a slot and raises o_res_rdy the next cycle.
//  - Push and pop in the same cycle: count unchanged, order preserved.
//  - Empty FIFO with i_rdy=1: no pop, o_vld=0.
//  - No sample is ever dropped or duplicated. Words leave in push order.
//  - Reset mid-word or mid-burst: partial word and all FIFO contents discarded.
// CONFIGURATION
//  - RES_PACK_STATS_EN defined:
//    - o_sat_cnt increments once per accepted sample that saturates.
//    - The counter sticks at 16'hFFFF and clears only on reset.
//  - RES_PACK_STATS_EN undefined: the counter is not built; o_sat_cnt is tied to 16'h0000.
// TESTING
//  1. SHIFT=0, i_rdy=1, samples 1..8, i_last=0
//     -> one word o_data=64'h0807060504030201, o_keep=8'hFF, o_last=0, o_vld 1 cycle after 8th sample.
//  2. Samples 300, 18'h3FFFF, 255, 0, then 4 zeros
//     -> lanes 0..3 = FF,FF,FF,00; with RES_PACK_STATS_EN o_sat_cnt=2, without =0.
//  3. Samples 10,20,30 with i_last on 30
//     -> o_data=64'h00000000001E140A, o_keep=8'h07, o_last=1; next sample starts at lane 0.
//  4. i_rdy=0, stream 40 samples 0..39
//     -> o_res_rdy drops after 32nd accept; i_rdy=1 then yields 5 words in order, first lane0=0, last lane7=39, no loss.
//  5. 5 samples accepted, rst_n pulsed low mid-word, then samples 1..8
//     -> all outputs 0 during reset; exactly one word 64'h0807060504030201 emitted.
//  6. SHIFT=4 build: 18'h00FF0 -> lane 8'hFF unsaturated; 18'h01000 -> 8'hFF saturated (o_sat_cnt +1 with macro).

Source files
------------

// File: rtl/core_res_packer.sv
// core_res_packer
//   Receive end of the core result path. Each accepted core result is
//   shifted right by SHIFT, clipped to an unsigned PIX_W-bit pixel, and
//   packed little-endian into a PACK_N-lane word. A word closes when its
//   last lane fills or when the sample carries i_last. Closed words go
//   into a FIFO_DEPTH-deep show-ahead FIFO that feeds the output writer.
//
//   Optional build macro: RES_PACK_STATS_EN adds a saturating 16-bit count
//   of clipped samples on o_sat_cnt. Without it, o_sat_cnt is tied to 0.
//
//   Ports
//     clk, rst_n     clock (rising edge), asynchronous active-low reset
//     i_res_vld      result sample valid
//     i_res          core result, unsigned RES_W bits
//     i_last         sample ends a row (only meaningful with i_res_vld)
//     o_res_rdy      packer can take a sample this cycle
//     o_data         packed word, lane 0 in the low PIX_W bits (oldest)
//     o_keep         lane-valid mask
//     o_last         word closes a row
//     o_vld          FIFO head valid
//     i_rdy          downstream accepts the head word
//     o_sat_cnt      saturated-sample count (0 unless RES_PACK_STATS_EN)
module core_res_packer #(
  parameter int RES_W      = 18,
  parameter int PIX_W      = 8,
  parameter int PACK_N     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int SHIFT      = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_res_vld,
  input  logic [RES_W-1:0]        i_res,
  input  logic                    i_last,
  output logic                    o_res_rdy,
  output logic [PACK_N*PIX_W-1:0] o_data,
  output logic [PACK_N-1:0]       o_keep,
  output logic                    o_last,
  output logic                    o_vld,
  input  logic                    i_rdy,
  output logic [15:0]             o_sat_cnt
);

  localparam int LANE_W = $clog2(PACK_N);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WORD_W = PACK_N * PIX_W;
  localparam logic [RES_W-1:0] PIX_MAX = RES_W'((1 << PIX_W) - 1);

  // True when the shifted result does not fit in a pixel.
  function automatic logic pix_sat(input logic [RES_W-1:0] r);
    logic [RES_W-1:0] s;
    s = r >> SHIFT;
    return (s > PIX_MAX);
  endfunction

  // Shift then clip to the largest pixel value.
  function automatic logic [PIX_W-1:0] pix_clip(input logic [RES_W-1:0] r);
    logic [RES_W-1:0] s;
    s = r >> SHIFT;
    if (s > PIX_MAX) return {PIX_W{1'b1}};
    return s[PIX_W-1:0];
  endfunction

  logic [LANE_W-1:0] lane_cnt_p0;
  logic [WORD_W-1:0] data_p0;
  logic [PACK_N-1:0] keep_p0;
  logic [WORD_W-1:0] data_nxt;
  logic [PACK_N-1:0] keep_nxt;
  logic              acc_p0;
  logic              close_p0;
  logic [PIX_W-1:0]  pix_p0;

  logic [WORD_W-1:0] fifo_data_p1 [FIFO_DEPTH];
  logic [PACK_N-1:0] fifo_keep_p1 [FIFO_DEPTH];
  logic              fifo_last_p1 [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_p1;
  logic [PTR_W-1:0]  rd_ptr_p1;
  logic [CNT_W-1:0]  cnt_p1;
  logic              vld_p1;
  logic              pop_p1;

  // ---- Stage p0: accept, clip, and pack into the partial word ----
  // Ready depends only on the registered FIFO occupancy, so a full FIFO
  // never sees a push; a pop reopens the input one cycle later.
  assign o_res_rdy = (cnt_p1 < CNT_W'(FIFO_DEPTH));
  assign acc_p0    = i_res_vld & o_res_rdy;
  assign close_p0  = acc_p0 & ((lane_cnt_p0 == LANE_W'(PACK_N - 1)) | i_last);
  assign pix_p0    = pix_clip(i_res);

  always_comb begin
    data_nxt = data_p0;
    keep_nxt = keep_p0;
    if (acc_p0) begin
      data_nxt[lane_cnt_p0*PIX_W +: PIX_W] = pix_p0;
      keep_nxt[lane_cnt_p0]                = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt_p0 <= '0;
      data_p0     <= '0;
      keep_p0     <= '0;
    end else if (close_p0) begin
      lane_cnt_p0 <= '0;
      data_p0     <= '0;
      keep_p0     <= '0;
    end else if (acc_p0) begin
      lane_cnt_p0 <= lane_cnt_p0 + 1'b1;
      data_p0     <= data_nxt;
      keep_p0     <= keep_nxt;
    end
  end

  // ---- Stage p1: word FIFO, pushed by the closing sample ----
  always_ff @(posedge clk) begin
    if (close_p0) begin
      fifo_data_p1[wr_ptr_p1] <= data_nxt;
      fifo_keep_p1[wr_ptr_p1] <= keep_nxt;
      fifo_last_p1[wr_ptr_p1] <= i_last;
    end
  end

  assign vld_p1 = (cnt_p1 != '0);
  assign pop_p1 = vld_p1 & i_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_p1 <= '0;
      rd_ptr_p1 <= '0;
      cnt_p1    <= '0;
    end else begin
      if (close_p0) wr_ptr_p1 <= wr_ptr_p1 + 1'b1;
      if (pop_p1)   rd_ptr_p1 <= rd_ptr_p1 + 1'b1;
      case ({close_p0, pop_p1})
        2'b10:   cnt_p1 <= cnt_p1 + 1'b1;
        2'b01:   cnt_p1 <= cnt_p1 - 1'b1;
        default: cnt_p1 <= cnt_p1;
      endcase
    end
  end

  // Storage is not reset; the head is masked so an empty FIFO shows zeros.
  assign o_vld  = vld_p1;
  assign o_data = vld_p1 ? fifo_data_p1[rd_ptr_p1] : '0;
  assign o_keep = vld_p1 ? fifo_keep_p1[rd_ptr_p1] : '0;
  assign o_last = vld_p1 ? fifo_last_p1[rd_ptr_p1] : 1'b0;

`ifdef RES_PACK_STATS_EN
  logic [15:0] sat_cnt_p0;

  // Sticks at all ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_p0 <= '0;
    end else if (acc_p0 && pix_sat(i_res) && (sat_cnt_p0 != 16'hFFFF)) begin
      sat_cnt_p0 <= sat_cnt_p0 + 16'd1;
    end
  end

  assign o_sat_cnt = sat_cnt_p0;
`else
  assign o_sat_cnt = 16'h0000;
`endif

endmodule
